// File: rtl/uart_sniffer.sv
// Passive multi-channel 8N1 UART receive monitor with fractional-rate 16x
// oversampling and a round-robin merge of received bytes onto one stream.
module uart_sniffer #(
    parameter int unsigned NUM_CH   = 10,
    parameter int unsigned ACC_BITS = 13,
    parameter int unsigned CH_BITS  = $clog2(NUM_CH)
) (
    input  logic                             clk,
    input  logic                             aresetn,
    input  logic [NUM_CH-1:0]                rx,
    input  logic [NUM_CH-1:0]                ch_enable,
    input  logic [NUM_CH*(ACC_BITS-1)-1:0]   tick_inc,
    output logic                             m_valid,
    input  logic                             m_ready,
    output logic [10+CH_BITS-1:0]            m_data
);

    localparam int unsigned INC_W = ACC_BITS - 1;
    localparam int unsigned SW    = CH_BITS + 1;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_START = 3'd1;
    localparam logic [2:0] S_DATA  = 3'd2;
    localparam logic [2:0] S_STOP  = 3'd3;
    localparam logic [2:0] S_BREAK = 3'd4;

    logic [NUM_CH-1:0]   rx_m;
    logic [NUM_CH-1:0]   rx_s;
    logic [ACC_BITS-1:0] acc_q   [NUM_CH];
    logic [NUM_CH-1:0]   tick;

    logic [2:0]          st_q    [NUM_CH];
    logic [2:0]          st_d    [NUM_CH];
    logic [3:0]          cnt_q   [NUM_CH];
    logic [3:0]          cnt_d   [NUM_CH];
    logic [2:0]          bit_q   [NUM_CH];
    logic [2:0]          bit_d   [NUM_CH];
    logic [7:0]          sh_q    [NUM_CH];
    logic [7:0]          sh_d    [NUM_CH];
    logic [NUM_CH-1:0]   cap;
    logic [NUM_CH-1:0]   cap_ferr;

    logic [NUM_CH-1:0]   pend_q;
    logic [NUM_CH-1:0]   ovr_q;
    logic [NUM_CH-1:0]   hferr_q;
    logic [7:0]          hbyte_q [NUM_CH];

    logic [CH_BITS-1:0]  last_q;
    logic [CH_BITS-1:0]  gnt_idx;
    logic [CH_BITS-1:0]  arb_cand;
    logic [SW-1:0]       arb_sum;
    logic                gnt_found;
    logic                load;
    logic [NUM_CH-1:0]   gnt_vec;

    // Two-flop synchroniser on every monitored line, idle-high reset
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            rx_m <= '1;
            rx_s <= '1;
        end else begin
            rx_m <= rx;
            rx_s <= rx_m;
        end
    end

    // Fractional tick accumulators; carry out is the oversampling tick
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            for (int i = 0; i < NUM_CH; i++) acc_q[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (!ch_enable[i]) acc_q[i] <= '0;
                else acc_q[i] <= {1'b0, acc_q[i][INC_W-1:0]}
                               + {1'b0, tick_inc[i*INC_W +: INC_W]};
            end
        end
    end

    // Tick is the accumulator carry bit
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) tick[i] = acc_q[i][ACC_BITS-1];
    end

    // Receiver state registers
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            for (int i = 0; i < NUM_CH; i++) begin
                st_q[i]  <= S_IDLE;
                cnt_q[i] <= '0;
                bit_q[i] <= '0;
                sh_q[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                st_q[i]  <= st_d[i];
                cnt_q[i] <= cnt_d[i];
                bit_q[i] <= bit_d[i];
                sh_q[i]  <= sh_d[i];
            end
        end
    end

    // Receiver next-state: 8N1 framing, advancing only on tick cycles
    always_comb begin
        cap      = '0;
        cap_ferr = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            st_d[i]  = st_q[i];
            cnt_d[i] = cnt_q[i];
            bit_d[i] = bit_q[i];
            sh_d[i]  = sh_q[i];
            if (!ch_enable[i]) begin
                st_d[i]  = S_IDLE;
                cnt_d[i] = '0;
                bit_d[i] = '0;
            end else if (tick[i]) begin
                case (st_q[i])
                    S_IDLE: begin
                        if (!rx_s[i]) begin
                            st_d[i]  = S_START;
                            cnt_d[i] = '0;
                        end
                    end
                    S_START: begin
                        if (cnt_q[i] == 4'd7) begin
                            cnt_d[i] = '0;
                            bit_d[i] = '0;
                            st_d[i]  = rx_s[i] ? S_IDLE : S_DATA;
                        end else begin
                            cnt_d[i] = cnt_q[i] + 4'd1;
                        end
                    end
                    S_DATA: begin
                        if (cnt_q[i] == 4'd15) begin
                            sh_d[i]  = {rx_s[i], sh_q[i][7:1]};
                            cnt_d[i] = '0;
                            if (bit_q[i] == 3'd7) st_d[i] = S_STOP;
                            else bit_d[i] = bit_q[i] + 3'd1;
                        end else begin
                            cnt_d[i] = cnt_q[i] + 4'd1;
                        end
                    end
                    S_STOP: begin
                        if (cnt_q[i] == 4'd15) begin
                            cap[i]      = 1'b1;
                            cap_ferr[i] = !rx_s[i];
                            cnt_d[i]    = '0;
                            st_d[i]     = rx_s[i] ? S_IDLE : S_BREAK;
                        end else begin
                            cnt_d[i] = cnt_q[i] + 4'd1;
                        end
                    end
                    S_BREAK: begin
                        if (rx_s[i]) st_d[i] = S_IDLE;
                    end
                    default: st_d[i] = S_IDLE;
                endcase
            end
        end
    end

    // Round-robin search for the first pending channel after the last grant
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = last_q;
        arb_sum   = '0;
        arb_cand  = '0;
        load      = !m_valid || m_ready;
        gnt_vec   = '0;
        for (int unsigned k = 1; k <= NUM_CH; k++) begin
            arb_sum = {1'b0, last_q} + SW'(k);
            if (arb_sum >= SW'(NUM_CH)) arb_sum = arb_sum - SW'(NUM_CH);
            arb_cand = arb_sum[CH_BITS-1:0];
            if (!gnt_found && pend_q[arb_cand]) begin
                gnt_found = 1'b1;
                gnt_idx   = arb_cand;
            end
        end
        for (int i = 0; i < NUM_CH; i++)
            gnt_vec[i] = load && gnt_found && (gnt_idx == CH_BITS'(i));
    end

    // Per-channel one-entry holding register; grant frees the slot the same edge
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            pend_q  <= '0;
            ovr_q   <= '0;
            hferr_q <= '0;
            for (int i = 0; i < NUM_CH; i++) hbyte_q[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (cap[i]) begin
                    if (pend_q[i] && !gnt_vec[i]) begin
                        ovr_q[i] <= 1'b1;
                    end else begin
                        pend_q[i]  <= 1'b1;
                        ovr_q[i]   <= 1'b0;
                        hferr_q[i] <= cap_ferr[i];
                        hbyte_q[i] <= sh_q[i];
                    end
                end else if (gnt_vec[i]) begin
                    pend_q[i] <= 1'b0;
                    ovr_q[i]  <= 1'b0;
                end
            end
        end
    end

    // Output beat register, reloaded whenever empty or accepted
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            m_valid <= 1'b0;
            m_data  <= '0;
            last_q  <= CH_BITS'(NUM_CH - 1);
        end else if (load) begin
            if (gnt_found) begin
                m_valid <= 1'b1;
                m_data  <= {ovr_q[gnt_idx], hferr_q[gnt_idx], gnt_idx, hbyte_q[gnt_idx]};
                last_q  <= gnt_idx;
            end else begin
                m_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_sniffer.sv
// Directed bench for uart_sniffer: 8N1 frames at 500 kbaud on a 100 MHz clock.
module tb_uart_sniffer;

    localparam int NUM_CH   = 10;
    localparam int ACC_BITS = 11;
    localparam int CH_BITS  = 4;
    localparam int DW       = 10 + CH_BITS;
    localparam int BIT_CLK  = 200;

    logic                           clk;
    logic                           aresetn;
    logic [NUM_CH-1:0]              rx;
    logic [NUM_CH-1:0]              ch_enable;
    logic [NUM_CH*(ACC_BITS-1)-1:0] tick_inc;
    logic                           m_valid;
    logic                           m_ready;
    logic [DW-1:0]                  m_data;

    logic [7:0]    tx_byte [NUM_CH];
    logic [DW-1:0] beats [$];
    int            n_checks;
    int            n_fail;
    int            wcnt;

    uart_sniffer #(.NUM_CH(NUM_CH), .ACC_BITS(ACC_BITS)) dut (
        .clk      (clk),
        .aresetn  (aresetn),
        .rx       (rx),
        .ch_enable(ch_enable),
        .tick_inc (tick_inc),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .m_data   (m_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record every accepted beat; data is stable around the falling edge
    always @(negedge clk) begin
        if (aresetn && m_valid && m_ready) beats.push_back(m_data);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [NUM_CH-1:0] mask, input logic stop, input int nbits);
        logic [9:0] fr;
        for (int b = 0; b < nbits; b++) begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (mask[i]) begin
                    fr = {stop, tx_byte[i], 1'b0};
                    rx[i] = fr[b];
                end
            end
            wait_clk(BIT_CLK);
        end
    endtask

    task automatic expect_beats(input string tag, input int n,
                                input logic [DW-1:0] e0, input logic [DW-1:0] e1,
                                input logic [DW-1:0] e2);
        logic [DW-1:0] ex [3];
        logic [DW-1:0] g;
        ex[0] = e0; ex[1] = e1; ex[2] = e2;
        check({tag, "_count"}, beats.size(), n);
        for (int k = 0; k < n; k++) begin
            g = (k < beats.size()) ? beats[k] : '1;
            check($sformatf("%s_beat%0d", tag, k), g, ex[k]);
        end
        beats.delete();
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        aresetn   = 1'b0;
        rx        = '1;
        ch_enable = '1;
        m_ready   = 1'b1;
        tick_inc  = {NUM_CH{10'd82}};
        for (int i = 0; i < NUM_CH; i++) tx_byte[i] = 8'h00;

        wait_clk(3);
        check("rst_valid", m_valid, 0);
        check("rst_data", m_data, 0);
        aresetn = 1'b1;
        wait_clk(20);

        // Single byte on ch0, beat shortly after the stop-bit sample
        tx_byte[0] = 8'hA5;
        send_frame(10'b1, 1'b1, 9);
        rx[0] = 1'b1;
        wcnt = 0;
        while (!m_valid && wcnt < BIT_CLK) begin
            wait_clk(1);
            wcnt++;
        end
        check("t1_valid_seen", m_valid, 1);
        check("t1_valid_window", (wcnt >= 60 && wcnt <= 160), 1);
        wait_clk(BIT_CLK - wcnt + 50);
        expect_beats("t1", 1, 14'h00A5, 0, 0);

        // Framing error with a break, then a clean frame on ch1
        tx_byte[1] = 8'h3C;
        send_frame(10'b10, 1'b0, 10);
        wait_clk(2 * BIT_CLK);
        expect_beats("t2_break", 1, 14'h113C, 0, 0);
        rx[1] = 1'b1;
        wait_clk(2 * BIT_CLK);
        tx_byte[1] = 8'h55;
        send_frame(10'b10, 1'b1, 10);
        wait_clk(50);
        expect_beats("t2_clean", 1, 14'h0155, 0, 0);

        // Short glitch on ch4 emits nothing and leaves the receiver ready
        rx[4] = 1'b0;
        wait_clk(50);
        rx[4] = 1'b1;
        wait_clk(2 * BIT_CLK);
        expect_beats("t3_glitch", 0, 0, 0, 0);
        tx_byte[4] = 8'h5A;
        send_frame(10'b1_0000, 1'b1, 10);
        wait_clk(50);
        expect_beats("t3_after", 1, 14'h045A, 0, 0);

        // Back-pressure and overrun on ch2
        m_ready = 1'b0;
        tx_byte[2] = 8'h11; send_frame(10'b100, 1'b1, 10);
        tx_byte[2] = 8'h22; send_frame(10'b100, 1'b1, 10);
        tx_byte[2] = 8'h33; send_frame(10'b100, 1'b1, 10);
        wait_clk(50);
        check("t4_hold_valid", m_valid, 1);
        check("t4_hold_data", m_data, 14'h0211);
        m_ready = 1'b1;
        wait_clk(10);
        expect_beats("t4_ovr", 2, 14'h0211, 14'h2222, 0);

        // Round robin from reset, then wrap after last grant ch3
        aresetn = 1'b0;
        wait_clk(2);
        check("t5_rst_valid", m_valid, 0);
        aresetn = 1'b1;
        wait_clk(20);
        tx_byte[0] = 8'hA0; tx_byte[1] = 8'hA1; tx_byte[3] = 8'hA3;
        send_frame(10'b1011, 1'b1, 10);
        wait_clk(50);
        expect_beats("t5_rr", 3, 14'h00A0, 14'h01A1, 14'h03A3);
        tx_byte[0] = 8'hB0; tx_byte[3] = 8'hB3;
        send_frame(10'b1001, 1'b1, 10);
        wait_clk(50);
        expect_beats("t5_wrap", 2, 14'h00B0, 14'h03B3, 0);

        // Reset mid-frame on ch5 with a beat stalled in the output register
        m_ready = 1'b0;
        tx_byte[6] = 8'h42;
        send_frame(10'b100_0000, 1'b1, 10);
        wait_clk(50);
        check("t6_stalled", m_valid, 1);
        tx_byte[5] = 8'h7E;
        send_frame(10'b10_0000, 1'b1, 4);
        #2 aresetn = 1'b0;
        #1;
        check("t6_rst_valid", m_valid, 0);
        check("t6_rst_data", m_data, 0);
        rx[5] = 1'b1;
        wait_clk(2);
        aresetn = 1'b1;
        wait_clk(2 * BIT_CLK);
        m_ready = 1'b1;
        beats.delete();
        send_frame(10'b10_0000, 1'b1, 10);
        wait_clk(50);
        expect_beats("t6_after", 1, 14'h057E, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
